// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Control unit for a multicycle RV32-style datapath. The FSM steps through
// FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB]. It raises a sticky trap on an
// unsupported opcode or when a memory request waits too long for its ack.
//
// Parameters
//   TIMEOUT     maximum cycles a memory request waits for ack before trapping
// Ports
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   i_opcode    instruction[6:0] from the instruction register
//   i_alu_zero  ALU zero flag (branch decision)
//   i_imem_ack  instruction memory data valid
//   i_dmem_ack  data memory access complete
//   o_imem_req  instruction fetch request
//   o_dmem_req  data memory request
//   o_dmem_we   data memory write enable
//   o_ir_load   instruction register load strobe
//   o_pc_en     PC update strobe
//   o_pc_src    PC source: 0=PC+4, 1=PC+imm
//   o_rf_wen    register file write strobe
//   o_wb_sel    writeback source: 0=ALU, 1=memory, 2=PC+4, 3=immediate
//   o_alu_src   1 selects the immediate as ALU operand 2
//   o_alu_op    ALU operation: 0=add, 1=sub/compare, 2=funct-decoded
//   o_state     current state encoding
//   o_trap      sticky fault flag
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic       i_alu_zero,
  input  logic       i_imem_ack,
  input  logic       i_dmem_ack,
  output logic       o_imem_req,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_ir_load,
  output logic       o_pc_en,
  output logic [1:0] o_pc_src,
  output logic       o_rf_wen,
  output logic [1:0] o_wb_sel,
  output logic       o_alu_src,
  output logic [1:0] o_alu_op,
  output logic [2:0] o_state,
  output logic       o_trap
);

  // Counter must be able to hold TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_wait_cnt;
  logic [CW-1:0]   w_wait_next;
  logic            w_timeout;
  logic            w_op_valid;
  logic            w_is_store;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_ir_load    = 1'b0;
    o_pc_en      = 1'b0;
    o_pc_src     = 2'd0;
    o_rf_wen     = 1'b0;
    o_wb_sel     = 2'd0;
    o_alu_src    = 1'b0;
    o_alu_op     = 2'd0;

    w_timeout  = (r_wait_cnt == TIMEOUT_C);
    w_is_store = (i_opcode == OP_STORE);
    w_op_valid = (i_opcode == OP_R)     || (i_opcode == OP_I)      ||
                 (i_opcode == OP_LOAD)  || (i_opcode == OP_STORE)  ||
                 (i_opcode == OP_BRANCH)|| (i_opcode == OP_JAL)    ||
                 (i_opcode == OP_LUI);

    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        // Ack on the timeout cycle still counts: ack is tested first.
        if (i_imem_ack) begin
          o_ir_load    = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_state_next = w_op_valid ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        case (i_opcode)
          OP_R: begin
            o_alu_op     = 2'd2;
            w_state_next = S_WB;
          end
          OP_I: begin
            o_alu_src    = 1'b1;
            o_alu_op     = 2'd2;
            w_state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            o_alu_src    = 1'b1;
            w_state_next = S_MEM;
          end
          OP_BRANCH: begin
            // Branch resolves here; no writeback stage.
            o_alu_op     = 2'd1;
            o_pc_en      = 1'b1;
            o_pc_src     = {1'b0, i_alu_zero};
            w_state_next = S_FETCH;
          end
          OP_JAL, OP_LUI: w_state_next = S_WB;
          default:        w_state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = w_is_store;
        if (i_dmem_ack) begin
          if (w_is_store) begin
            o_pc_en      = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
        end
      end
      S_WB: begin
        o_rf_wen = 1'b1;
        o_pc_en  = 1'b1;
        case (i_opcode)
          OP_LOAD: o_wb_sel = 2'd1;
          OP_JAL:  o_wb_sel = 2'd2;
          OP_LUI:  o_wb_sel = 2'd3;
          default: o_wb_sel = 2'd0;
        endcase
        o_pc_src     = (i_opcode == OP_JAL) ? 2'd1 : 2'd0;
        w_state_next = S_FETCH;
      end
      S_TRAP:  w_state_next = S_TRAP;
      default: w_state_next = S_TRAP;
    endcase

    // Counter restarts on every state change, so it is zero on entry to
    // FETCH and MEM; it only advances while a request waits unanswered.
    if (w_state_next != r_state) begin
      w_wait_next = '0;
    end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
      w_wait_next = r_wait_cnt + 1'b1;
    end else begin
      w_wait_next = r_wait_cnt;
    end

    // Nothing leaves the block while reset is held, even if acks arrive.
    if (i_rst) begin
      o_imem_req = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_ir_load  = 1'b0;
      o_pc_en    = 1'b0;
      o_rf_wen   = 1'b0;
    end
  end

  assign o_state = r_state;
  assign o_trap  = (r_state == S_TRAP) && !i_rst;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench: each issued instruction pushes its expected outcome
// (cycle count, strobe counts, selects) computed from the instruction rules;
// a monitor accumulates DUT activity and pops/compares when an instruction
// retires (o_pc_en) or traps.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int T = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_opcode = 7'd0;
  logic       i_alu_zero = 1'b0;
  logic       i_imem_ack = 1'b0;
  logic       i_dmem_ack = 1'b0;
  logic       o_imem_req, o_dmem_req, o_dmem_we, o_ir_load, o_pc_en;
  logic [1:0] o_pc_src, o_wb_sel, o_alu_op;
  logic       o_rf_wen, o_alu_src, o_trap;
  logic [2:0] o_state;

  multicycle_control #(.TIMEOUT(T)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_opcode   (i_opcode),
    .i_alu_zero (i_alu_zero),
    .i_imem_ack (i_imem_ack),
    .i_dmem_ack (i_dmem_ack),
    .o_imem_req (o_imem_req),
    .o_dmem_req (o_dmem_req),
    .o_dmem_we  (o_dmem_we),
    .o_ir_load  (o_ir_load),
    .o_pc_en    (o_pc_en),
    .o_pc_src   (o_pc_src),
    .o_rf_wen   (o_rf_wen),
    .o_wb_sel   (o_wb_sel),
    .o_alu_src  (o_alu_src),
    .o_alu_op   (o_alu_op),
    .o_state    (o_state),
    .o_trap     (o_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit   trap;
    int   cycles;
    int   rf_n;
    int   wb_sel;
    int   pc_src;
    int   dmem_n;
    int   dmem_we;
    int   ir_n;
    bit   has_exec;
    int   alu_src;
    int   alu_op;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic bit is_valid(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

  // Reference model: instruction outcome from the instruction-level rules.
  // Cycle count runs from the first FETCH cycle to the retiring (pc_en) cycle,
  // or to the first TRAP cycle inclusive.
  function automatic exp_t model(input logic [6:0] op, input int iw, input int dw,
                                 input logic z);
    exp_t e;
    int   f;
    e = '{default: 0};
    if (iw > T) begin
      e.trap = 1; e.cycles = T + 2;
      return e;
    end
    f = iw + 1;
    e.ir_n = 1;
    case (op)
      OP_R:   begin e.cycles = f + 3; e.rf_n = 1; e.has_exec = 1; e.alu_op = 2; end
      OP_I:   begin e.cycles = f + 3; e.rf_n = 1; e.has_exec = 1; e.alu_op = 2; e.alu_src = 1; end
      OP_JAL: begin e.cycles = f + 3; e.rf_n = 1; e.has_exec = 1; e.wb_sel = 2; e.pc_src = 1; end
      OP_LUI: begin e.cycles = f + 3; e.rf_n = 1; e.has_exec = 1; e.wb_sel = 3; end
      OP_BRANCH: begin
        e.cycles = f + 2; e.has_exec = 1; e.alu_op = 1; e.pc_src = int'(z);
      end
      OP_LOAD, OP_STORE: begin
        e.has_exec = 1; e.alu_src = 1;
        e.dmem_we  = (op == OP_STORE) ? 1 : 0;
        if (dw > T) begin
          e.trap = 1; e.dmem_n = T + 1; e.cycles = f + 2 + (T + 1) + 1;
        end else begin
          e.dmem_n = dw + 1;
          if (op == OP_LOAD) begin
            e.cycles = f + 2 + dw + 1 + 1; e.rf_n = 1; e.wb_sel = 1;
          end else begin
            e.cycles = f + 2 + dw + 1;
          end
        end
      end
      default: begin e.trap = 1; e.cycles = f + 2; end
    endcase
    return e;
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0, ir_n = 0, rf_n = 0, wb_seen = 0, dmem_n = 0, we_seen = 0;
  bit in_trap = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        cyc = 0; ir_n = 0; rf_n = 0; wb_seen = 0; dmem_n = 0; we_seen = 0; in_trap = 0;
      end else if (in_trap) begin
        chk("trap_hold", int'({o_trap, o_state, o_pc_en, o_rf_wen, o_ir_load, o_imem_req, o_dmem_req}),
            int'(9'b1_101_00000));
      end else begin
        cyc++;
        if (o_ir_load) ir_n++;
        if (o_rf_wen) begin rf_n++; wb_seen = int'(o_wb_sel); end
        if (o_dmem_req) begin dmem_n++; if (o_dmem_we) we_seen = 1; end
        if (o_state == 3'd2 && sb_q.size() > 0 && sb_q[0].has_exec) begin
          chk("exec_alu_src", int'(o_alu_src), sb_q[0].alu_src);
          chk("exec_alu_op", int'(o_alu_op), sb_q[0].alu_op);
        end
        if (o_trap || o_pc_en) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("event_kind", int'(o_trap), int'(e.trap));
            chk("cycles", cyc, e.cycles);
            chk("ir_load_count", ir_n, e.ir_n);
            chk("rf_wen_count", rf_n, e.rf_n);
            chk("dmem_req_cycles", dmem_n, e.dmem_n);
            chk("dmem_we", we_seen, e.dmem_we);
            if (o_pc_en) begin
              chk("pc_src", int'(o_pc_src), e.pc_src);
              if (e.rf_n > 0) chk("wb_sel", wb_seen, e.wb_sel);
            end
          end
          in_trap = o_trap;
          cyc = 0; ir_n = 0; rf_n = 0; wb_seen = 0; dmem_n = 0; we_seen = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic noise_cycle();
    i_imem_ack = 1'($urandom % 2);
    i_dmem_ack = 1'($urandom % 2);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_imem_ack = 1'($urandom % 2);
    i_dmem_ack = 1'($urandom % 2);
    #1;
    chk("reset_strobes", int'({o_pc_en, o_rf_wen, o_ir_load, o_imem_req, o_dmem_req}), 0);
    @(posedge clk); #1;
    chk("reset_strobes_held", int'({o_pc_en, o_rf_wen, o_ir_load, o_imem_req, o_dmem_req}), 0);
    chk("reset_state", int'(o_state), 0);
    chk("reset_trap", int'(o_trap), 0);
    i_rst = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
    #1;
    chk("post_reset_imem_req", int'(o_imem_req), 1);
  endtask

  task automatic do_instr(input logic [6:0] op, input int iw, input int dw, input logic z);
    exp_t e;
    int   nf, nm;
    e = model(op, iw, dw, z);
    sb_q.push_back(e);
    i_opcode = op; i_alu_zero = z;
    nf = (iw > T) ? T + 1 : iw + 1;
    for (int k = 0; k < nf; k++) begin
      i_imem_ack = (iw <= T) && (k == iw);
      i_dmem_ack = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    if (iw <= T) begin
      if (!is_valid(op)) begin
        noise_cycle();
      end else begin
        noise_cycle();
        noise_cycle();
        if (op == OP_LOAD || op == OP_STORE) begin
          nm = (dw > T) ? T + 1 : dw + 1;
          for (int k = 0; k < nm; k++) begin
            i_dmem_ack = (dw <= T) && (k == dw);
            i_imem_ack = 1'($urandom % 2);
            @(posedge clk); #1;
          end
        end
        if (e.rf_n > 0 && !e.trap) noise_cycle();
      end
    end
    i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
    if (e.trap) begin
      repeat (4) noise_cycle();
      do_reset();
    end
    $display("instr op=%b iw=%0d dw=%0d z=%0d trap=%0d exp_cycles=%0d", op, iw, dw, z, e.trap, e.cycles);
  endtask

  // Reset pulsed while a store waits in MEM, with dmem ack arriving the same cycle.
  task automatic do_abort_store(input int iw, input int hold);
    i_opcode = OP_STORE;
    for (int k = 0; k <= iw; k++) begin
      i_imem_ack = (k == iw); @(posedge clk); #1;
    end
    i_imem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    repeat (hold) begin @(posedge clk); #1; end
    chk("abort_in_mem", int'(o_state), 3);
    i_rst = 1'b1; i_dmem_ack = 1'b1;
    #1;
    chk("abort_strobes", int'({o_pc_en, o_rf_wen, o_dmem_req}), 0);
    @(posedge clk); #1;
    chk("abort_state", int'(o_state), 0);
    i_rst = 1'b0; i_dmem_ack = 1'b0;
    $display("abort store iw=%0d hold=%0d", iw, hold);
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] op;
    int r;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    do_instr(OP_R, 2, 0, 1'b0);       // states 0,0,0,1,2,4
    do_instr(OP_LOAD, 0, 3, 1'b0);    // MEM held 4 cycles
    do_instr(OP_BRANCH, 1, 0, 1'b1);  // taken branch, pc_src=1
    do_instr(OP_BRANCH, 0, 0, 1'b0);
    do_instr(OP_STORE, 1, 2, 1'b0);
    do_instr(OP_JAL, 0, 0, 1'b0);
    do_instr(OP_LUI, 3, 0, 1'b0);
    do_instr(OP_I, 0, 0, 1'b0);
    do_instr(OP_R, T, 0, 1'b0);       // ack exactly at timeout: ack wins
    do_instr(OP_STORE, 0, T, 1'b0);   // dmem ack exactly at timeout
    do_instr(7'b1111111, 0, 0, 1'b0); // unsupported opcode -> trap
    do_instr(OP_R, T + 1, 0, 1'b0);   // fetch timeout -> trap
    do_instr(OP_LOAD, 1, T + 1, 1'b0);// data timeout -> trap
    do_abort_store(1, 2);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom % 20);
      if (r == 0) begin
        op = 7'($urandom);
        if (is_valid(op)) op = 7'b1111111;
        do_instr(op, int'($urandom % (T + 1)), 0, 1'b0);
      end else if (r == 1) begin
        do_instr(ops[$urandom % 7], T + 1, 0, 1'b0);
      end else if (r == 2) begin
        do_instr(($urandom % 2) ? OP_LOAD : OP_STORE, int'($urandom % (T + 1)), T + 1, 1'b0);
      end else begin
        do_instr(ops[$urandom % 7], int'($urandom % (T + 1)), int'($urandom % (T + 1)),
                 1'($urandom % 2));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
